// File: rtl/par2ser_pkg.sv
// Shared definitions for the parallel-to-serial stream converter:
// FSM state encoding and the legal range of the word width.
package par2ser_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHIFT  = 2'b01;
    localparam logic [1:0] ST_PARITY = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

endpackage

// File: rtl/par2ser_shreg.sv
// Word buffer for par2ser_stream: parallel load, zero-filled shift toward
// the output end, serial bit taken from the MSB or LSB depending on LSB_FIRST.
module par2ser_shreg #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              sout
);

    logic [DATA_W-1:0] buff;

    // Load has priority so a word can reload on the edge its last bit retires.
    always_ff @(posedge clock) begin
        if (!rst)
            buff <= '0;
        else if (load)
            buff <= din;
        else if (shift)
            buff <= LSB_FIRST ? {1'b0, buff[DATA_W-1:1]} : {buff[DATA_W-2:0], 1'b0};
    end

    assign sout = LSB_FIRST ? buff[0] : buff[DATA_W-1];

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with valid/ready load, bit-rate enable,
// selectable bit order and back-to-back streaming.
// Optional feature: define PAR2SER_PARITY_EN to append an even-parity slot
// after each word.
module par2ser_stream
    import par2ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              srl,
    output logic              valid,
    output logic              first,
    output logic              last
);

    localparam int             CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_W - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
        $error("par2ser_stream: DATA_W out of range");
    end

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          final_slot, rdy, load, shift, sbit;

`ifdef PAR2SER_PARITY_EN
    logic par_q;

    // Parity of the word is captured at load; the buffer is zeroed by then.
    always_ff @(posedge clock) begin
        if (!rst)
            par_q <= 1'b0;
        else if (load)
            par_q <= ^s_data;
    end

    assign final_slot = (state == PARITY);
`else
    assign final_slot = (state == SHIFT) && (count == LAST_CNT);
`endif

    // Ready is combinational from en so streaming has no idle gap.
    assign rdy  = (state == IDLE) || (final_slot && en);
    assign load = s_valid && rdy;

    par2ser_shreg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clock (clock),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (s_data),
        .sout  (sbit)
    );

    // State and bit counter registers.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Next-state, counter and shift control; en=0 holds everything.
    always_comb begin
        state_nx = state;
        count_nx = count;
        shift    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT;
                    count_nx = '0;
                end
            end
            SHIFT: begin
                if (en) begin
                    shift = 1'b1;
                    if (count == LAST_CNT) begin
`ifdef PAR2SER_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = load ? SHIFT : IDLE;
                        count_nx = '0;
`endif
                    end else begin
                        count_nx = count + CW'(1);
                    end
                end
            end
`ifdef PAR2SER_PARITY_EN
            PARITY: begin
                if (en) begin
                    state_nx = load ? SHIFT : IDLE;
                    count_nx = '0;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted.
    assign valid   = rst && (state != IDLE);
    assign first   = valid && (state == SHIFT) && (count == '0);
    assign last    = valid && final_slot;
    assign s_ready = rst && rdy;
`ifdef PAR2SER_PARITY_EN
    assign srl     = valid && ((state == PARITY) ? par_q : sbit);
`else
    assign srl     = valid && sbit;
`endif

endmodule
